// File: rtl/sva_stim_gen.sv
// sva_stim_gen: steps out c/b symbol traces of the language c=1, b=0^g0 1 0^g1 1 with optional error injection,
// alongside the checker state and verdict that a correct checker should report.
module sva_stim_gen #(
  parameter int GAP_W = 4,
  parameter int IDX_W = GAP_W + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             step,
  input  logic [GAP_W-1:0] cfg_gap0,
  input  logic [GAP_W-1:0] cfg_gap1,
  input  logic             cfg_inject,
  input  logic [IDX_W-1:0] cfg_err_idx,
  output logic             busy,
  output logic             c_o,
  output logic             b_o,
  output logic             sym_valid,
  output logic [IDX_W-1:0] sym_idx,
  output logic [2:0]       exp_state,
  output logic             done,
  output logic             exp_succ,
  output logic             exp_fail
);
  typedef enum logic [2:0] {IDLE, GAP0, HIT1, GAP1, HIT2} state_t;
  state_t r_state, w_state;
  logic [GAP_W-1:0] r_gap0, r_gap1, r_cnt, w_gap0, w_gap1, w_cnt;
  logic [IDX_W-1:0] r_err_idx, r_idx, r_sym_idx, w_err_idx, w_idx, w_sym_idx;
  logic [2:0] r_exp, w_exp;
  logic r_inject, r_c, r_b, r_valid, r_done, r_succ, r_fail;
  logic w_inject, w_c, w_b, w_valid, w_done, w_succ, w_fail, w_err, w_hit;
  function automatic logic [2:0] nx_exp(input logic [2:0] s, input logic c, input logic b);
    return !c ? 3'd5 :
           (s == 3'd0 || s == 3'd2) ? (b ? 3'd1 : 3'd2) :
           (s == 3'd1 || s == 3'd3) ? (b ? 3'd4 : 3'd3) : s;
  endfunction
  always_comb begin
    w_state   = r_state;
    w_gap0    = r_gap0;
    w_gap1    = r_gap1;
    w_cnt     = r_cnt;
    w_inject  = r_inject;
    w_err_idx = r_err_idx;
    w_idx     = r_idx;
    w_sym_idx = r_sym_idx;
    w_exp     = r_exp;
    w_c       = r_c;
    w_b       = r_b;
    w_valid   = 1'b0;
    w_done    = 1'b0;
    w_succ    = 1'b0;
    w_fail    = 1'b0;
    w_err     = r_inject && (r_idx == r_err_idx);
    w_hit     = (r_state == HIT1) || (r_state == HIT2);
    if (abort) begin
      w_state   = IDLE;
      w_c       = 1'b0;
      w_b       = 1'b0;
      w_exp     = 3'd0;
      w_sym_idx = '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        w_gap0    = cfg_gap0;
        w_gap1    = cfg_gap1;
        w_inject  = cfg_inject;
        w_err_idx = cfg_err_idx;
        w_idx     = '0;
        w_cnt     = '0;
        w_exp     = 3'd0;
        w_state   = (cfg_gap0 == '0) ? HIT1 : GAP0;
      end
    end else if (step) begin
      w_c       = !w_err;
      w_b       = !w_err && w_hit;
      w_valid   = 1'b1;
      w_sym_idx = r_idx;
      w_idx     = r_idx + IDX_W'(1);
      w_cnt     = r_cnt + GAP_W'(1);
      w_exp     = nx_exp(r_exp, w_c, w_b);
      if (w_err) begin
        w_state = IDLE;
        w_done  = 1'b1;
        w_fail  = 1'b1;
      end else if (r_state == GAP0) begin
        w_state = (r_cnt == r_gap0 - GAP_W'(1)) ? HIT1 : GAP0;
      end else if (r_state == HIT1) begin
        w_cnt   = '0;
        w_state = (r_gap1 == '0) ? HIT2 : GAP1;
      end else if (r_state == GAP1) begin
        w_state = (r_cnt == r_gap1 - GAP_W'(1)) ? HIT2 : GAP1;
      end else begin
        w_state = IDLE;
        w_done  = 1'b1;
        w_succ  = 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_gap0    <= '0;
      r_gap1    <= '0;
      r_cnt     <= '0;
      r_inject  <= 1'b0;
      r_err_idx <= '0;
      r_idx     <= '0;
      r_sym_idx <= '0;
      r_exp     <= 3'd0;
      r_c       <= 1'b0;
      r_b       <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_succ    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_gap0    <= w_gap0;
      r_gap1    <= w_gap1;
      r_cnt     <= w_cnt;
      r_inject  <= w_inject;
      r_err_idx <= w_err_idx;
      r_idx     <= w_idx;
      r_sym_idx <= w_sym_idx;
      r_exp     <= w_exp;
      r_c       <= w_c;
      r_b       <= w_b;
      r_valid   <= w_valid;
      r_done    <= w_done;
      r_succ    <= w_succ;
      r_fail    <= w_fail;
    end
  end
  assign busy      = (r_state != IDLE);
  assign c_o       = r_c;
  assign b_o       = r_b;
  assign sym_valid = r_valid;
  assign sym_idx   = r_sym_idx;
  assign exp_state = r_exp;
  assign done      = r_done;
  assign exp_succ  = r_succ;
  assign exp_fail  = r_fail;
endmodule

// File: tb/tb_sva_stim_gen.sv
// tb_sva_stim_gen: directed traces with hand-computed symbol, checker-state and verdict expectations.
module tb_sva_stim_gen;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0, abort = 1'b0, step = 1'b0, cfg_inject = 1'b0;
  logic [3:0] cfg_gap0 = '0, cfg_gap1 = '0;
  logic [4:0] cfg_err_idx = '0;
  logic busy, c_o, b_o, sym_valid, done, exp_succ, exp_fail;
  logic [4:0] sym_idx;
  logic [2:0] exp_state;
  int total = 0, bad = 0;
  sva_stim_gen dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort), .step(step),
    .cfg_gap0(cfg_gap0), .cfg_gap1(cfg_gap1), .cfg_inject(cfg_inject), .cfg_err_idx(cfg_err_idx),
    .busy(busy), .c_o(c_o), .b_o(b_o), .sym_valid(sym_valid), .sym_idx(sym_idx),
    .exp_state(exp_state), .done(done), .exp_succ(exp_succ), .exp_fail(exp_fail)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [3:0] g0, input logic [3:0] g1, input logic inj, input logic [4:0] err);
    @(negedge sys_clk);
    cfg_gap0 = g0; cfg_gap1 = g1; cfg_inject = inj; cfg_err_idx = err; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("start", {busy, sym_valid, exp_state}, {1'b1, 1'b0, 3'd0});
  endtask
  task automatic sym(input string tag, input logic c, input logic b, input logic [4:0] idx,
                     input logic [2:0] st, input logic d, input logic s, input logic f);
    @(negedge sys_clk);
    step = 1'b1;
    @(negedge sys_clk);
    step = 1'b0;
    chk(tag, {sym_valid, c_o, b_o, sym_idx, exp_state, done, exp_succ, exp_fail},
        {1'b1, c, b, idx, st, d, s, f});
  endtask
  task automatic quiet(input string tag, input logic busy_e);
    @(negedge sys_clk);
    chk(tag, {busy, sym_valid, done, exp_succ, exp_fail}, {busy_e, 4'b0});
  endtask
  task automatic trace_2_1();
    sym("t40_s0", 1, 0, 0, 2, 0, 0, 0);
    quiet("t40_gap", 1);
    chk("t40_hold", {c_o, b_o}, 2'b10);
    sym("t40_s1", 1, 0, 1, 2, 0, 0, 0);
    sym("t40_s2", 1, 1, 2, 1, 0, 0, 0);
    sym("t40_s3", 1, 0, 3, 3, 0, 0, 0);
    sym("t40_s4", 1, 1, 4, 4, 1, 1, 0);
    quiet("t40_end", 0);
    chk("t40_after", {c_o, b_o, exp_state}, {2'b11, 3'd4});
  endtask
  initial begin
    #12;
    chk("reset", {busy, c_o, b_o, sym_valid, sym_idx, exp_state, done, exp_succ, exp_fail}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    step = 1'b1;
    @(negedge sys_clk);
    step = 1'b0;
    chk("idle_step", {busy, sym_valid}, 2'b00);
    cfg_gap0 = 4'd2; cfg_gap1 = 4'd1; cfg_inject = 1'b0; start = 1'b1; step = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; step = 1'b0;
    chk("start_step", {busy, sym_valid, exp_state}, {1'b1, 1'b0, 3'd0});
    trace_2_1();
    go(0, 0, 0, 0);
    sym("t41_s0", 1, 1, 0, 1, 0, 0, 0);
    sym("t41_s1", 1, 1, 1, 4, 1, 1, 0);
    quiet("t41_end", 0);
    go(1, 1, 1, 2);
    sym("t42_s0", 1, 0, 0, 2, 0, 0, 0);
    sym("t42_s1", 1, 1, 1, 1, 0, 0, 0);
    sym("t42_s2", 0, 0, 2, 5, 1, 0, 1);
    @(negedge sys_clk);
    step = 1'b1;
    @(negedge sys_clk);
    step = 1'b0;
    chk("t42_extra", {busy, sym_valid, c_o, b_o, done}, 5'b0);
    go(1, 1, 1, 9);
    sym("t43_s0", 1, 0, 0, 2, 0, 0, 0);
    sym("t43_s1", 1, 1, 1, 1, 0, 0, 0);
    sym("t43_s2", 1, 0, 2, 3, 0, 0, 0);
    sym("t43_s3", 1, 1, 3, 4, 1, 1, 0);
    go(2, 1, 0, 0);
    sym("t44_s0", 1, 0, 0, 2, 0, 0, 0);
    sym("t44_s1", 1, 0, 1, 2, 0, 0, 0);
    @(negedge sys_clk);
    abort = 1'b1; step = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0; step = 1'b0; start = 1'b0;
    chk("t44_abort", {busy, c_o, b_o, sym_valid, exp_state, done, exp_succ, exp_fail}, 32'd0);
    quiet("t44_idle", 0);
    go(2, 1, 0, 0);
    trace_2_1();
    go(3, 3, 0, 0);
    sym("t45_s0", 1, 0, 0, 2, 0, 0, 0);
    @(negedge sys_clk);
    cfg_gap0 = 4'd0; cfg_gap1 = 4'd0; cfg_inject = 1'b1; cfg_err_idx = 5'd1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("t45_busy_start", {busy, sym_valid}, 2'b10);
    sym("t45_s1", 1, 0, 1, 2, 0, 0, 0);
    sym("t45_s2", 1, 0, 2, 2, 0, 0, 0);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("t45_rst", {busy, c_o, b_o, sym_valid, sym_idx, exp_state, done, exp_succ, exp_fail}, 32'd0);
    repeat (2) @(negedge sys_clk);
    chk("t45_rst_hold", {busy, c_o, b_o, done}, 4'd0);
    sys_rst_n = 1'b1;
    go(0, 0, 0, 0);
    sym("t45_p0", 1, 1, 0, 1, 0, 0, 0);
    sym("t45_p1", 1, 1, 1, 4, 1, 1, 0);
    quiet("t45_end", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sva_stim_gen.md
SVA_STIM_GEN -- requirements
Module: sva_stim_gen

Interface
REQ-001 Parameter GAP_W, default 4: width of gap-length configuration fields.
REQ-002 Parameter IDX_W, default GAP_W+1: width of symbol index and error-position fields.
REQ-003 sys_clk  in  1  single block clock; all state updates on its rising edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a new trace; accepted only in IDLE.
REQ-006 abort  in  1  synchronous cancel of the trace in progress.
REQ-007 step  in  1  single-cycle pulse (user-clock posedge flag); emits one symbol per pulse while busy.
REQ-008 cfg_gap0  in  GAP_W  count of c=1,b=0 symbols before the first b=1.
REQ-009 cfg_gap1  in  GAP_W  count of c=1,b=0 symbols between the first and second b=1.
REQ-010 cfg_inject  in  1  enable error injection.
REQ-011 cfg_err_idx  in  IDX_W  0-based symbol index at which the error symbol replaces the legal symbol.
REQ-012 busy  out  1  trace in progress.
REQ-013 c_o, b_o  out  1 each  stimulus symbol for the checker inputs c and b.
REQ-014 sym_valid  out  1  one-cycle pulse when c_o/b_o are updated.
REQ-015 sym_idx  out  IDX_W  index of the symbol currently on c_o/b_o.
REQ-016 exp_state  out  3  checker state after this symbol: 0=S0, 1=S1, 2=S2, 3=S3, 4=SEND, 5=FAIL.
REQ-017 done, exp_succ, exp_fail  out  1 each  one-cycle end-of-trace pulse, with the expected checker verdict.

Function
REQ-018 The block SHALL generate traces of the checker language c=1 throughout, b = 0^gap0 1 0^gap1 1, total length L = gap0+gap1+2.
REQ-019 The state machine SHALL have states IDLE, GAP0, HIT1, GAP1, HIT2.
REQ-020 start in IDLE SHALL capture all cfg_* inputs, set busy=1, reset the index to 0 and exp_state to S0, and select GAP0, or HIT1 if cfg_gap0=0.
REQ-021 cfg_* changes while busy SHALL have no effect.
REQ-022 start while busy SHALL be ignored.
REQ-023 step in IDLE SHALL be ignored.
REQ-024 step in the cycle start is accepted SHALL be ignored; the first symbol SHALL be emitted on the first step after acceptance.
REQ-025 Each step while busy SHALL, one cycle later, update c_o/b_o, pulse sym_valid, set sym_idx to the symbol index, and increment the internal index.
REQ-026 GAP0 and GAP1 SHALL each emit (c=1,b=0) exactly their captured gap count, then advance (GAP0 to HIT1, GAP1 to HIT2); a zero gap SHALL skip the state.
REQ-027 HIT1 and HIT2 SHALL each emit (c=1,b=1) once.
REQ-028 exp_state SHALL follow the checker transitions: b=1 takes S0/S2 to S1 and S1/S3 to SEND; b=0 takes S0/S2 to S2 and S1/S3 to S3; c=0 takes any state to FAIL.
REQ-029 If cfg_inject=1 and the index equals cfg_err_idx, the symbol SHALL be (c=0,b=0).
REQ-030 On an injected symbol: exp_state=FAIL, done=1 and exp_fail=1 with that sym_valid, then return to IDLE.
REQ-031 If cfg_err_idx >= L, no error SHALL be injected.
REQ-032 The HIT2 symbol SHALL pulse done=1 and exp_succ=1 with its sym_valid, then return to IDLE with busy=0.
REQ-033 exp_succ and exp_fail SHALL never be asserted together.
REQ-034 c_o/b_o SHALL hold between symbols and after done, until the next emitted symbol.
REQ-035 abort SHALL take priority over step and start: return to IDLE, busy=0, c_o=b_o=0, exp_state=S0, no done, exp_succ or exp_fail pulse.
REQ-036 The index counter SHALL not wrap within a trace; the maximum L = 2*(2^GAP_W-1)+2 SHALL fit in IDX_W bits.

Reset
REQ-037 Assertion of sys_rst_n=0 SHALL immediately force state IDLE and busy, c_o, b_o, sym_valid, done, exp_succ, exp_fail to 0, and sym_idx, exp_state to 0.
REQ-038 Reset mid-trace SHALL discard the trace without any done pulse.
REQ-039 After deassertion, the first accepted start SHALL behave as from power-up.

Verification
REQ-040 gap0=2, gap1=1, no inject, 5 steps -> b_o sequence 0,0,1,0,1 with c_o=1; exp_state 2,2,1,3,4; done+exp_succ on idx 4.
REQ-041 gap0=0, gap1=0 -> b_o 1,1; exp_state 1,4; done+exp_succ on idx 1; busy low the cycle after.
REQ-042 gap0=1, gap1=1, inject, err_idx=2 -> symbols (1,0),(1,1),(0,0); exp_state 2,1,5; done+exp_fail on idx 2; no further symbols on extra steps.
REQ-043 inject with err_idx=9, L=4 -> normal trace, exp_succ=1.
REQ-044 abort after 2 symbols, concurrent with step -> busy=0, c_o=b_o=0, no done; a following start runs a full correct trace.
REQ-045 sys_rst_n low mid-trace and start while busy with new cfg -> outputs zero during reset; cfg changes ignored while busy.
